// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared seg display definitions: stopwatch states and timing defaults
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_t;

  localparam int         CNT_MAX_DEF  = 2_400_000;
  localparam int         MAX_VAL_DEF  = 999_999;
  localparam int         DATA_W       = 20;
  localparam logic [5:0] POINT_TENTHS = 6'b000010;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every CNT_MAX enabled cycles
module tick_gen
  import seg_display_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
  localparam logic [PW-1:0] LAST = PW'(CNT_MAX - 1);

  logic [PW-1:0] pre;

  assign tick = enable && !clear && (pre == LAST);

  // Holding when disabled keeps the partial period across a pause.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      if (pre == LAST) pre <= '0;
      else             pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM with lap freeze, wrapping 0.1 s count and display outputs
module stopwatch_ctrl
  import seg_display_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int MAX_VAL = MAX_VAL_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              key_start,
  input  logic              key_clear,
  input  logic              key_lap,
  output logic [DATA_W-1:0] data,
  output logic [5:0]        point,
  output logic              en,
  output logic              sign,
  output logic [1:0]        state,
  output logic              overflow
);

  sw_state_t         cur;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] lap_reg;
  logic              tick;
  logic              do_clear;
  logic              pre_en;
  logic              pre_clr;

  assign state    = cur;
  assign do_clear = (cur == ST_PAUSE) && key_clear;
  assign pre_en   = (cur == ST_RUN) || (cur == ST_LAP);
  assign pre_clr  = (cur == ST_IDLE) || do_clear;

  tick_gen #(.CNT_MAX(CNT_MAX)) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (pre_en),
    .clear     (pre_clr),
    .tick      (tick)
  );

  // Keys invalid in the current state never reach a branch, so priority only
  // needs ordering among the valid ones: clear > start > lap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur     <= ST_IDLE;
      lap_reg <= '0;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (key_start) cur <= ST_RUN;
        end
        ST_RUN: begin
          if (key_start) begin
            cur <= ST_PAUSE;
          end else if (key_lap) begin
            cur     <= ST_LAP;
            lap_reg <= count;
          end
        end
        ST_LAP: begin
          if (key_start)    cur <= ST_PAUSE;
          else if (key_lap) cur <= ST_RUN;
        end
        ST_PAUSE: begin
          if (key_clear)      cur <= ST_IDLE;
          else if (key_start) cur <= ST_RUN;
        end
        default: cur <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (tick) begin
      if (count == DATA_W'(MAX_VAL)) begin
        count    <= '0;
        overflow <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data  <= '0;
      point <= '0;
      en    <= 1'b0;
      sign  <= 1'b0;
    end else begin
      data  <= (cur == ST_LAP) ? lap_reg : count;
      point <= POINT_TENTHS;
      en    <= 1'b1;
      sign  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven bench for stopwatch_ctrl with CNT_MAX=4
module tb_stopwatch_ctrl;

  typedef struct {
    bit          sel;
    bit          rst;
    bit          ks;
    bit          kc;
    bit          kl;
    int          wait_n;
    logic [1:0]  st;
    logic [19:0] d;
    logic        ov;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic ks0 = 1'b0, kc0 = 1'b0, kl0 = 1'b0;
  logic ks1 = 1'b0, kc1 = 1'b0, kl1 = 1'b0;

  logic [19:0] d0, d1;
  logic [5:0]  pt0, pt1;
  logic        en0, en1, sg0, sg1, ov0, ov1;
  logic [1:0]  st0, st1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 sys_clk = ~sys_clk;

  stopwatch_ctrl #(.CNT_MAX(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .key_start(ks0), .key_clear(kc0), .key_lap(kl0),
    .data(d0), .point(pt0), .en(en0), .sign(sg0), .state(st0), .overflow(ov0)
  );

  stopwatch_ctrl #(.CNT_MAX(4), .MAX_VAL(9)) dut_ov (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .key_start(ks1), .key_clear(kc1), .key_lap(kl1),
    .data(d1), .point(pt1), .en(en1), .sign(sg1), .state(st1), .overflow(ov1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit rst, input bit ks, input bit kc, input bit kl,
                     input int n, input logic [1:0] st, input logic [19:0] d, input logic ov);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ks = ks; v.kc = kc; v.kl = kl;
    v.wait_n = n; v.st = st; v.d = d; v.ov = ov;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    // Time is counted in edges after each key press (P0 = first start edge).
    add(0, 1, 1, 0, 0,  41, 2'b01, 20'd10, 1'b0);
    add(0, 1, 1, 0, 0,  29, 2'b01, 20'd7,  1'b0);
    add(0, 0, 1, 0, 0, 100, 2'b10, 20'd7,  1'b0);
    add(0, 0, 1, 0, 0,   2, 2'b01, 20'd7,  1'b0);
    add(0, 0, 0, 0, 0,   0, 2'b01, 20'd8,  1'b0);
    add(0, 1, 1, 0, 0,  21, 2'b01, 20'd5,  1'b0);
    add(0, 0, 0, 0, 1,  10, 2'b11, 20'd5,  1'b0);
    add(0, 0, 0, 0, 0,  15, 2'b11, 20'd5,  1'b0);
    add(0, 0, 0, 0, 1,   1, 2'b01, 20'd12, 1'b0);
    add(0, 0, 0, 1, 0,   0, 2'b01, 20'd12, 1'b0);
    add(0, 0, 1, 0, 0,   1, 2'b10, 20'd13, 1'b0);
    add(0, 0, 1, 1, 0,   1, 2'b00, 20'd0,  1'b0);
    add(0, 0, 0, 1, 1,   5, 2'b00, 20'd0,  1'b0);
    add(0, 0, 1, 0, 0,   4, 2'b01, 20'd0,  1'b0);
    add(0, 0, 0, 0, 0,   0, 2'b01, 20'd1,  1'b0);
    add(0, 0, 1, 0, 1,   0, 2'b10, 20'd1,  1'b0);
    add(0, 0, 1, 0, 0,   0, 2'b01, 20'd1,  1'b0);
    add(0, 0, 0, 0, 1,   0, 2'b11, 20'd1,  1'b0);
    add(0, 0, 1, 0, 0,   1, 2'b10, 20'd2,  1'b0);
    add(1, 1, 1, 0, 0,  37, 2'b01, 20'd9,  1'b0);
    add(1, 0, 0, 0, 0,   3, 2'b01, 20'd0,  1'b1);
    add(1, 0, 1, 0, 0,   0, 2'b10, 20'd0,  1'b1);
    add(1, 0, 0, 1, 0,   1, 2'b00, 20'd0,  1'b0);

    // Reset state, with a start pulse that must be ignored under reset.
    #12;
    check("rst state", 32'(st0), 32'd0);
    check("rst data",  32'(d0),  32'd0);
    check("rst point", 32'(pt0), 32'd0);
    check("rst en",    32'(en0), 32'd0);
    check("rst sign",  32'(sg0), 32'd0);
    check("rst ovf",   32'(ov0), 32'd0);
    ks0 = 1'b1;
    @(negedge sys_clk);
    ks0 = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("post-rst state", 32'(st0), 32'd0);
    check("post-rst point", 32'(pt0), 32'h02);
    check("post-rst en",    32'(en0), 32'd1);
    check("post-rst sign",  32'(sg0), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) do_reset();
      if (v.sel) {ks1, kc1, kl1} = {v.ks, v.kc, v.kl};
      else       {ks0, kc0, kl0} = {v.ks, v.kc, v.kl};
      @(negedge sys_clk);
      {ks0, kc0, kl0, ks1, kc1, kl1} = '0;
      repeat (v.wait_n) @(negedge sys_clk);
      check($sformatf("row%0d state", i), 32'(v.sel ? st1 : st0), 32'(v.st));
      check($sformatf("row%0d data",  i), 32'(v.sel ? d1 : d0),   32'(v.d));
      check($sformatf("row%0d ovf",   i), 32'(v.sel ? ov1 : ov0), 32'(v.ov));
      check($sformatf("row%0d point", i), 32'(v.sel ? pt1 : pt0), 32'h02);
      check($sformatf("row%0d en",    i), 32'(v.sel ? en1 : en0), 32'd1);
    end

    // Asynchronous reset mid-RUN must clear outputs before the next edge.
    do_reset();
    ks0 = 1'b1;
    @(negedge sys_clk);
    ks0 = 1'b0;
    repeat (30) @(negedge sys_clk);
    check("async pre data", 32'(d0), 32'd7);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async state", 32'(st0), 32'd0);
    check("async data",  32'(d0),  32'd0);
    check("async point", 32'(pt0), 32'd0);
    check("async en",    32'(en0), 32'd0);
    check("async sign",  32'(sg0), 32'd0);
    check("async ovf",   32'(ov0), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CNT_MAX, default 2_400_000, sys_clk cycles per 0.1 s tick.
REQ-002 Parameter MAX_VAL, default 999_999, highest count value before wrap.
REQ-003 sys_clk  input  1  system clock.
REQ-004 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 key_start  input  1  debounced single-cycle pulse; start/stop toggle.
REQ-006 key_clear  input  1  debounced single-cycle pulse; clear count.
REQ-007 key_lap  input  1  debounced single-cycle pulse; lap freeze/release.
REQ-008 data  output  20  value to display, units of 0.1 s.
REQ-009 point  output  6  per-digit decimal point enable, active-high.
REQ-010 en  output  1  display enable.
REQ-011 sign  output  1  negative-sign enable.
REQ-012 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-013 overflow  output  1  sticky flag; count wrapped past MAX_VAL.

Function
REQ-014 The FSM SHALL use states IDLE, RUN, PAUSE and LAP, with transitions taking effect on the clock edge that samples the key pulse.
REQ-015 IDLE: key_start -> RUN; key_clear and key_lap are ignored.
REQ-016 RUN: key_start -> PAUSE; key_lap -> LAP with the current count latched into the lap register; key_clear is ignored.
REQ-017 LAP: key_lap -> RUN; key_start -> PAUSE; key_clear is ignored.
REQ-018 PAUSE: key_start -> RUN; key_clear -> IDLE with the count, prescaler and overflow zeroed; key_lap is ignored.
REQ-019 Simultaneous pulses SHALL resolve with priority clear > start > lap, considering only keys that are valid in the current state.
REQ-020 The prescaler SHALL count only in RUN and LAP, hold in PAUSE (the fraction is retained), and be zero on leaving IDLE.
REQ-021 The tick SHALL be a one-cycle pulse when the prescaler equals CNT_MAX-1, with the prescaler wrapping to 0 on the same edge.
REQ-022 The 20-bit binary count SHALL increment on each tick; a tick at MAX_VAL SHALL load 0 and set overflow.
REQ-023 overflow SHALL remain set until a clear in PAUSE or a reset.
REQ-024 data SHALL be registered: in LAP it shows the lap register; in every other state it shows the count, one clock after the count updates.
REQ-025 In LAP the count SHALL keep running while data stays frozen; leaving LAP SHALL show the live count on the next clock.
REQ-026 After reset release, point SHALL be 6'b000010 (tenths separator), en SHALL be 1 and sign SHALL be 0, all from the first clock edge onward.

Reset
REQ-027 Asserting sys_rst_n low SHALL immediately force state=IDLE and zero data, point, en, sign, overflow, the count, the prescaler and the lap register, including mid-RUN.
REQ-028 Key pulses SHALL be ignored while reset is asserted.

Structure
REQ-029 The state encodings and the default values of CNT_MAX and MAX_VAL SHALL live in the shared seg display definitions package, also used by the display driver.
REQ-030 The prescaler SHALL be the sub-module tick_gen, with ports: enable, synchronous clear, tick output, and parameter CNT_MAX.
REQ-031 The FSM, the count, the lap register and the output registers SHALL reside in stopwatch_ctrl; the target size is 120-400 RTL lines in total.

Verification (bench uses CNT_MAX=4 unless stated)
REQ-032 Reset release, then key_start -> state=01; after 40 cycles plus 1 cycle latency, data=10, point=000010, en=1, sign=0.
REQ-033 key_start at data=7 -> state=10; data holds 7 over 100 cycles; key_start again -> the next increment arrives after the remaining prescaler cycles, not a full 4.
REQ-034 key_lap at data=5 -> state=11 and data holds 5; key_lap again after 7 further ticks -> data=12 and state=01.
REQ-035 With MAX_VAL=9: 10 ticks -> data=0 and overflow=1; key_start then key_clear -> state=00, data=0, overflow=0.
REQ-036 In PAUSE, key_clear and key_start in the same cycle -> IDLE with data=0; key_clear in RUN -> no change.
REQ-037 Assert sys_rst_n low mid-RUN between clock edges -> all outputs 0 and state=00 immediately, before the next edge.
